imm_decode_stage: RTL and testbench

Registered, flow-controlled immediate generator for the decode stage. It replaces the combinational immediate mux with a parametrised XLEN (32/64) unit that adds CSR-zimm, shift-amount and illegal-select decoding, and fixes the architectural U-type encoding. The output is buffered through a two-entry skid stage with valid/ready handshakes, so the decode stage can stall and flush it without dropping instructions. It sits between fetch/decode control and the execute-stage operand mux.

---
 rtl/core_pkg.sv | 19 +
 rtl/imm_format_dec.sv | 43 ++++
 rtl/imm_decode_stage.sv | 84 ++++++++
 tb/tb_imm_decode_stage.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// core_pkg: shared decode-stage types and parameter checks
package core_pkg;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_J,
        IMM_U,
        IMM_Z,
        IMM_SH,
        IMM_RSV
    } imm_sel_e;

    function automatic bit xlen_ok(int unsigned xlen);
        return xlen == 32 || xlen == 64;
    endfunction

endpackage

// File: rtl/imm_format_dec.sv
// imm_format_dec: combinational RISC-V immediate extraction for all formats
module imm_format_dec
    import core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    input  imm_sel_e        sel,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    logic signed [11:0] i_imm;
    logic signed [11:0] s_imm;
    logic signed [12:0] b_imm;
    logic signed [20:0] j_imm;
    logic signed [31:0] u_imm;
    logic               unused_opcode;

    assign i_imm = inst[31:20];
    assign s_imm = {inst[31:25], inst[11:7]};
    assign b_imm = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign j_imm = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    assign u_imm = {inst[31:12], 12'b0};
    assign unused_opcode = ^inst[6:0];

    // select the format; signed fields sign-extend through the width cast
    always_comb begin
        imm     = '0;
        illegal = 1'b0;
        case (sel)
            IMM_I:   imm = XLEN'(i_imm);
            IMM_S:   imm = XLEN'(s_imm);
            IMM_B:   imm = XLEN'(b_imm);
            IMM_J:   imm = XLEN'(j_imm);
            IMM_U:   imm = XLEN'(u_imm);
            IMM_Z:   imm = XLEN'(inst[19:15]);
            IMM_SH:  imm = XLEN == 64 ? XLEN'(inst[25:20]) : XLEN'(inst[24:20]);
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_decode_stage.sv
// imm_decode_stage: registered immediate generator behind a two-entry skid buffer
module imm_decode_stage
    import core_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [2:0]       in_sel,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    logic [XLEN-1:0]  dec_imm;
    logic             dec_illegal;
    logic             skid_valid;
    logic [XLEN-1:0]  skid_imm;
    logic [TAG_W-1:0] skid_tag;
    logic             skid_illegal;
    logic             accept;
    logic             drain;

    if (!xlen_ok(XLEN)) begin : g_bad_xlen
        $error("imm_decode_stage: XLEN must be 32 or 64");
    end

    imm_format_dec #(.XLEN(XLEN)) u_dec (
        .inst    (in_inst),
        .sel     (imm_sel_e'(in_sel)),
        .imm     (dec_imm),
        .illegal (dec_illegal)
    );

    // ready depends only on the registered skid valid, never on out_ready
    assign in_ready = rst_n && !skid_valid;
    assign accept   = in_valid && in_ready;
    assign drain    = out_valid && out_ready;

    // OUT/SKID buffer: flush kills both valids, FULL only drains, else load OUT or spill to SKID
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_imm      <= '0;
            out_tag      <= '0;
            out_illegal  <= 1'b0;
            skid_valid   <= 1'b0;
            skid_imm     <= '0;
            skid_tag     <= '0;
            skid_illegal <= 1'b0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (skid_valid) begin
            if (drain) begin
                out_imm     <= skid_imm;
                out_tag     <= skid_tag;
                out_illegal <= skid_illegal;
                skid_valid  <= 1'b0;
            end
        end else if (accept && (!out_valid || drain)) begin
            out_valid   <= 1'b1;
            out_imm     <= dec_imm;
            out_tag     <= in_tag;
            out_illegal <= dec_illegal;
        end else if (accept) begin
            skid_valid   <= 1'b1;
            skid_imm     <= dec_imm;
            skid_tag     <= in_tag;
            skid_illegal <= dec_illegal;
        end else if (drain) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_imm_decode_stage.sv
// tb_imm_decode_stage: XLEN=32 and XLEN=64 instances checked against a queue model
module tb_imm_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] in_inst = '0;
    logic [2:0]  in_sel = '0;
    logic [31:0] in_tag = '0;

    logic        rdy32, rdy64, ov32, ov64, il32, il64;
    logic [31:0] imm32, tag32, tag64;
    logic [63:0] imm64;

    typedef struct {
        logic [63:0] i64;
        logic [31:0] i32;
        logic [31:0] tag;
        logic        ill;
    } ent_t;

    ent_t q[$];
    int   total = 0;
    int   bad = 0;

    logic [31:0] v_inst [7] = '{32'hFFF00093, 32'h12345037, 32'h80000037, 32'hFE000EE3,
                                32'h000FD073, 32'hDEADBEEF, 32'h02500013};
    logic [2:0]  v_sel  [7] = '{3'd0, 3'd4, 3'd4, 3'd2, 3'd5, 3'd7, 3'd6};
    logic [63:0] v_e64  [7] = '{64'hFFFFFFFFFFFFFFFF, 64'h12345000, 64'hFFFFFFFF80000000,
                                64'hFFFFFFFFFFFFFFFC, 64'h1F, 64'h0, 64'h25};
    logic [31:0] v_e32  [7] = '{32'hFFFFFFFF, 32'h12345000, 32'h80000000, 32'hFFFFFFFC,
                                32'h1F, 32'h0, 32'h05};

    always #5 clk = ~clk;

    imm_decode_stage #(.XLEN(32), .TAG_W(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy32),
        .in_inst(in_inst), .in_sel(in_sel), .in_tag(in_tag), .flush(flush),
        .out_valid(ov32), .out_ready(out_ready), .out_imm(imm32),
        .out_tag(tag32), .out_illegal(il32)
    );

    imm_decode_stage #(.XLEN(64), .TAG_W(32)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy64),
        .in_inst(in_inst), .in_sel(in_sel), .in_tag(in_tag), .flush(flush),
        .out_valid(ov64), .out_ready(out_ready), .out_imm(imm64),
        .out_tag(tag64), .out_illegal(il64)
    );

    function automatic longint sext(longint v, int bits);
        return v >= (longint'(1) << (bits - 1)) ? v - (longint'(1) << bits) : v;
    endfunction

    function automatic logic [63:0] ref_imm(logic [31:0] x, int sel, bit is64);
        longint u = longint'(x);
        case (sel)
            0: return sext(u >> 20, 12);
            1: return sext(((u >> 25) << 5) | ((u >> 7) & 31), 12);
            2: return sext(((u >> 31) << 12) | (((u >> 7) & 1) << 11) |
                           (((u >> 25) & 63) << 5) | (((u >> 8) & 15) << 1), 13);
            3: return sext(((u >> 31) << 20) | (((u >> 12) & 255) << 12) |
                           (((u >> 20) & 1) << 11) | (((u >> 21) & 1023) << 1), 21);
            4: return sext(u & 64'hFFFFF000, 32);
            5: return (u >> 15) & 31;
            6: return is64 ? (u >> 20) & 63 : (u >> 20) & 31;
            default: return 64'd0;
        endcase
    endfunction

    // advance one clock, updating the FIFO model with the inputs held across the edge
    task automatic tick();
        ent_t        e;
        logic [63:0] t;
        bit          acc, drn;
        if (!rst_n) begin
            q.delete();
        end else begin
            acc = in_valid && q.size() < 2;
            drn = q.size() > 0 && out_ready;
            if (drn) q.delete(0);
            if (flush) begin
                q.delete();
            end else if (acc) begin
                e.i64 = ref_imm(in_inst, int'(in_sel), 1'b1);
                t     = ref_imm(in_inst, int'(in_sel), 1'b0);
                e.i32 = t[31:0];
                e.tag = in_tag;
                e.ill = in_sel == 3'd7;
                q.push_back(e);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        total++;
        if ({ov32, ov64, il32, il64, rdy32, rdy64} !== 6'b0) begin
            bad++;
            $display("FAIL reset_flags got=%b required=000000", {ov32, ov64, il32, il64, rdy32, rdy64});
        end
        total++;
        if (imm32 !== 32'h0 || imm64 !== 64'h0 || tag32 !== 32'h0 || tag64 !== 32'h0) begin
            bad++;
            $display("FAIL reset_data got imm=%h/%h tag=%h/%h required=0", imm32, imm64, tag32, tag64);
        end
        rst_n = 1'b1;
        #1;
        total++;
        if (rdy32 !== 1'b1 || rdy64 !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_ready got=%b/%b required=1", rdy32, rdy64);
        end
    endtask

    task automatic test_formats();
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            in_inst  = v_inst[i];
            in_sel   = v_sel[i];
            in_tag   = 32'(100 + i);
            tick();
            total++;
            if (ov32 !== 1'b1 || ov64 !== 1'b1 || imm32 !== v_e32[i] || imm64 !== v_e64[i] ||
                il32 !== (i == 5) || il64 !== (i == 5) || tag32 !== 32'(100 + i) || tag64 !== 32'(100 + i)) begin
                bad++;
                $display("FAIL format_%0d got v=%b/%b imm=%h/%h ill=%b/%b tag=%0d required imm=%h/%h ill=%b tag=%0d",
                         i, ov32, ov64, imm32, imm64, il32, il64, tag32, v_e32[i], v_e64[i], i == 5, 100 + i);
            end
        end
        in_valid = 1'b0;
        tick();
        total++;
        if (ov32 !== 1'b0 || ov64 !== 1'b0) begin
            bad++;
            $display("FAIL format_drain got=%b/%b required=0", ov32, ov64);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_tag [6] = '{32'd1, 32'd1, 32'd1, 32'd2, 32'd3, 32'd0};
        logic        exp_rdy [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic        exp_ov  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        in_inst   = 32'hFFF00093;
        in_sel    = 3'd0;
        out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            in_valid  = c < 5;
            in_tag    = c < 2 ? 32'(c + 1) : 32'd3;
            out_ready = c >= 3;
            tick();
            total++;
            if (ov32 !== exp_ov[c] || ov64 !== exp_ov[c] || rdy32 !== exp_rdy[c] || rdy64 !== exp_rdy[c] ||
                (exp_ov[c] && (tag32 !== exp_tag[c] || tag64 !== exp_tag[c]))) begin
                bad++;
                $display("FAIL backpressure_c%0d got v=%b/%b rdy=%b/%b tag=%0d/%0d required v=%b rdy=%b tag=%0d",
                         c, ov32, ov64, rdy32, rdy64, tag32, tag64, exp_ov[c], exp_rdy[c], exp_tag[c]);
            end
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sel    = 3'd4;
        in_inst   = 32'h12345037;
        in_tag    = 32'd10;
        tick();
        in_tag = 32'd11;
        tick();
        total++;
        if (rdy32 !== 1'b0 || rdy64 !== 1'b0) begin
            bad++;
            $display("FAIL flush_full got rdy=%b/%b required=0", rdy32, rdy64);
        end
        flush  = 1'b1;
        in_tag = 32'd99;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        total++;
        if (ov32 !== 1'b0 || ov64 !== 1'b0 || rdy32 !== 1'b1 || rdy64 !== 1'b1) begin
            bad++;
            $display("FAIL flush_empty got v=%b/%b rdy=%b/%b required v=0 rdy=1", ov32, ov64, rdy32, rdy64);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            total++;
            if (ov32 !== 1'b0 || ov64 !== 1'b0) begin
                bad++;
                $display("FAIL flush_leak c=%0d got v=%b/%b tag=%0d required v=0", c, ov32, ov64, tag32);
            end
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sel    = 3'd0;
        in_inst   = 32'hFFF00093;
        in_tag    = 32'd7;
        tick();
        in_tag = 32'd8;
        tick();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        tick();
        total++;
        if ({ov32, ov64, il32, il64, rdy32, rdy64} !== 6'b0 || imm32 !== 32'h0 || imm64 !== 64'h0 ||
            tag32 !== 32'h0 || tag64 !== 32'h0) begin
            bad++;
            $display("FAIL reset_mid got v=%b/%b rdy=%b/%b imm=%h/%h tag=%0d/%0d required all 0",
                     ov32, ov64, rdy32, rdy64, imm32, imm64, tag32, tag64);
        end
        rst_n     = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_sel    = 3'd4;
        in_inst   = 32'h12345037;
        in_tag    = 32'd55;
        tick();
        in_valid = 1'b0;
        total++;
        if (ov32 !== 1'b1 || ov64 !== 1'b1 || tag32 !== 32'd55 || tag64 !== 32'd55 ||
            imm32 !== 32'h12345000 || imm64 !== 64'h12345000) begin
            bad++;
            $display("FAIL reset_first_accept got v=%b/%b tag=%0d/%0d imm=%h/%h required v=1 tag=55 imm=12345000",
                     ov32, ov64, tag32, tag64, imm32, imm64);
        end
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            in_valid  = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 2) != 0;
            flush     = $urandom_range(0, 31) == 0;
            in_inst   = $urandom;
            in_sel    = 3'($urandom_range(0, 7));
            in_tag    = $urandom;
            total++;
            if (rdy32 !== (q.size() < 2) || rdy64 !== (q.size() < 2)) begin
                bad++;
                $display("FAIL rand_ready c=%0d got=%b/%b required=%b", c, rdy32, rdy64, q.size() < 2);
            end
            tick();
            total++;
            if (ov32 !== (q.size() > 0) || ov64 !== (q.size() > 0)) begin
                bad++;
                $display("FAIL rand_valid c=%0d got=%b/%b required=%b", c, ov32, ov64, q.size() > 0);
            end else if (q.size() > 0) begin
                total++;
                if (imm32 !== q[0].i32 || imm64 !== q[0].i64 || tag32 !== q[0].tag || tag64 !== q[0].tag ||
                    il32 !== q[0].ill || il64 !== q[0].ill) begin
                    bad++;
                    $display("FAIL rand_data c=%0d got imm=%h/%h tag=%h/%h ill=%b/%b required imm=%h/%h tag=%h ill=%b",
                             c, imm32, imm64, tag32, tag64, il32, il64, q[0].i32, q[0].i64, q[0].tag, q[0].ill);
                end
            end
        end
        flush    = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_formats();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
